// File: rtl/mem_store_buffer_pkg.sv
// Shared types for the MEM-stage store buffer, used by the MEM stage,
// the cache FSM and the buffer itself.
package mem_store_buffer_pkg;

   localparam int SB_ADDR_W = 32;
   localparam int SB_DATA_W = 32;

   typedef struct packed {
      logic                 valid;
      logic [SB_ADDR_W-1:0] addr;
      logic [SB_DATA_W-1:0] data;
   } sb_entry_t;

endpackage

// File: rtl/mem_store_buffer_if.sv
// Enqueue / drain / forwarding bundle between MEM stage, store buffer and cache FSM.
interface mem_store_buffer_if
   import mem_store_buffer_pkg::*;
#(
   parameter int ENTRY_COUNT = 4,
   parameter int CNT_W       = $clog2(ENTRY_COUNT + 1)
);

   logic                 enq_valid;
   logic [SB_ADDR_W-1:0] enq_addr;
   logic [SB_DATA_W-1:0] enq_data;
   logic                 enq_ready;
   logic                 deq_req;
   logic [SB_ADDR_W-1:0] deq_addr;
   logic [SB_DATA_W-1:0] deq_data;
   logic                 deq_valid;
   logic [SB_ADDR_W-1:0] load_addr;
   logic [SB_DATA_W-1:0] sb_load_data;
   logic                 sb_load_hit;
   logic [CNT_W-1:0]     count_out;
   logic                 full;
   logic                 flush;

   // Requester side: MEM stage plus the draining cache FSM.
   modport master (
      output enq_valid, enq_addr, enq_data, deq_req, load_addr, flush,
      input  enq_ready, deq_addr, deq_data, deq_valid,
             sb_load_data, sb_load_hit, count_out, full
   );

   modport slave (
      input  enq_valid, enq_addr, enq_data, deq_req, load_addr, flush,
      output enq_ready, deq_addr, deq_data, deq_valid,
             sb_load_data, sb_load_hit, count_out, full
   );

endinterface

// File: rtl/mem_store_buffer.sv
// Word-granular FIFO store buffer between MEM stage and data cache, with
// youngest-match load forwarding from registered entries.
module mem_store_buffer
   import mem_store_buffer_pkg::*;
#(
   parameter int ENTRY_COUNT = 4
)
(
   input logic               clock,
   input logic               reset,
   mem_store_buffer_if.slave sb
);

   localparam int PTR_W = (ENTRY_COUNT > 1) ? $clog2(ENTRY_COUNT) : 1;
   localparam int CNT_W = $clog2(ENTRY_COUNT + 1);

   sb_entry_t          store_buf   [ENTRY_COUNT];
   sb_entry_t          store_buf_d [ENTRY_COUNT];
   logic [PTR_W-1:0]   head_q, head_d;
   logic [PTR_W-1:0]   tail_q, tail_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               full_w, empty_w;
   logic               enq_fire, deq_fire;
   logic [SB_DATA_W:0] fwd_w;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(ENTRY_COUNT - 1)) ? '0 : p + 1'b1;
   endfunction

   // Walk back from tail-1 over the live entries; the first hit is the youngest store.
   function automatic logic [SB_DATA_W:0] fwd_search(
      input sb_entry_t              ents [ENTRY_COUNT],
      input logic [PTR_W-1:0]       tail,
      input logic [CNT_W-1:0]       cnt,
      input logic [SB_ADDR_W-1:2]   waddr
   );
      logic [SB_DATA_W:0] res;
      logic               found;
      int                 idx;
      res   = '0;
      found = 1'b0;
      for (int i = 0; i < ENTRY_COUNT; i++) begin
         idx = (int'(tail) + 2 * ENTRY_COUNT - 1 - i) % ENTRY_COUNT;
         if (!found && (i < int'(cnt)) && ents[idx].valid &&
             (ents[idx].addr[SB_ADDR_W-1:2] == waddr)) begin
            found = 1'b1;
            res   = {1'b1, ents[idx].data};
         end
      end
      return res;
   endfunction

   assign full_w   = (count_q == CNT_W'(ENTRY_COUNT));
   assign empty_w  = (count_q == '0);
   assign enq_fire = sb.enq_valid && !full_w;
   assign deq_fire = sb.deq_req && !empty_w;

   always_comb begin
      store_buf_d = store_buf;
      head_d      = head_q;
      tail_d      = tail_q;
      count_d     = count_q;
      if (sb.flush) begin
         for (int i = 0; i < ENTRY_COUNT; i++) begin
            store_buf_d[i].valid = 1'b0;
         end
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (deq_fire) begin
            store_buf_d[head_q].valid = 1'b0;
            head_d                    = ptr_inc(head_q);
         end
         // Enqueue never targets the dequeuing slot: it is blocked when full.
         if (enq_fire) begin
            store_buf_d[tail_q] = '{valid: 1'b1, addr: sb.enq_addr, data: sb.enq_data};
            tail_d              = ptr_inc(tail_q);
         end
         count_d = count_q + CNT_W'(enq_fire) - CNT_W'(deq_fire);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < ENTRY_COUNT; i++) begin
            store_buf[i].valid <= 1'b0;
         end
      end else begin
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         store_buf <= store_buf_d;
      end
   end

   assign fwd_w = fwd_search(store_buf, tail_q, count_q, sb.load_addr[SB_ADDR_W-1:2]);

   assign sb.enq_ready    = !full_w;
   assign sb.full         = full_w;
   assign sb.count_out    = count_q;
   assign sb.deq_valid    = !empty_w;
   assign sb.deq_addr     = empty_w ? '0 : store_buf[head_q].addr;
   assign sb.deq_data     = empty_w ? '0 : store_buf[head_q].data;
   assign sb.sb_load_hit  = fwd_w[SB_DATA_W];
   assign sb.sb_load_data = fwd_w[SB_DATA_W-1:0];

endmodule

// File: tb/tb_mem_store_buffer.sv
// Directed bench for mem_store_buffer: FIFO order, full/wrap, forwarding, flush, reset.
module tb_mem_store_buffer;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;

   mem_store_buffer_if #(.ENTRY_COUNT(4)) sbif ();

   mem_store_buffer #(.ENTRY_COUNT(4)) dut (
      .clock (clk),
      .reset (rst),
      .sb    (sbif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_invalid(input string tag);
      for (int i = 0; i < 4; i++) begin
         check(tag, 32'(dut.store_buf[i].valid), 32'd0);
      end
   endtask

   initial begin
      logic [31:0] exp_addr [6];
      logic [31:0] exp_data [6];
      vectors     = 0;
      miscompares = 0;
      rst = 1'b1;
      sbif.enq_valid = 1'b0;
      sbif.enq_addr  = '0;
      sbif.enq_data  = '0;
      sbif.deq_req   = 1'b0;
      sbif.load_addr = '0;
      sbif.flush     = 1'b0;
      step();
      step();
      rst = 1'b0;
      step();

      // Reset / idle
      check("rst_count", 32'(sbif.count_out), 32'd0);
      check("rst_full", 32'(sbif.full), 32'd0);
      check("rst_enq_ready", 32'(sbif.enq_ready), 32'd1);
      check("rst_deq_valid", 32'(sbif.deq_valid), 32'd0);
      check("rst_hit", 32'(sbif.sb_load_hit), 32'd0);
      check("rst_deq_addr", sbif.deq_addr, 32'd0);

      // Two enqueues, then one dequeue
      sbif.enq_valid = 1'b1; sbif.enq_addr = 32'h100; sbif.enq_data = 32'hA;
      step();
      sbif.enq_addr = 32'h104; sbif.enq_data = 32'hB;
      step();
      sbif.enq_valid = 1'b0;
      check("two_count", 32'(sbif.count_out), 32'd2);
      check("two_deq_addr", sbif.deq_addr, 32'h100);
      check("two_deq_data", sbif.deq_data, 32'hA);
      sbif.deq_req = 1'b1;
      #1;
      check("deq_req_no_comb", sbif.deq_addr, 32'h100);
      step();
      sbif.deq_req = 1'b0;
      check("deq1_addr", sbif.deq_addr, 32'h104);
      check("deq1_data", sbif.deq_data, 32'hB);
      check("deq1_count", 32'(sbif.count_out), 32'd1);

      // Fill to 4 entries: 0x104, 0x108, 0x10C, 0x110
      sbif.enq_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         sbif.enq_addr = 32'h108 + 32'(4 * k);
         sbif.enq_data = 32'hC + 32'(k);
         step();
      end
      check("fill_count", 32'(sbif.count_out), 32'd4);
      check("fill_full", 32'(sbif.full), 32'd1);
      check("fill_enq_ready", 32'(sbif.enq_ready), 32'd0);

      // Enqueue while full alongside a dequeue: only the dequeue happens
      sbif.enq_addr = 32'h114; sbif.enq_data = 32'hF; sbif.deq_req = 1'b1;
      step();
      check("full_pair_count", 32'(sbif.count_out), 32'd3);
      check("full_pair_head", sbif.deq_addr, 32'h108);

      // Six enqueue/dequeue pairs across the pointer wrap
      exp_addr[0] = 32'h108; exp_data[0] = 32'hC;
      exp_addr[1] = 32'h10C; exp_data[1] = 32'hD;
      exp_addr[2] = 32'h110; exp_data[2] = 32'hE;
      exp_addr[3] = 32'h120; exp_data[3] = 32'h20;
      exp_addr[4] = 32'h124; exp_data[4] = 32'h21;
      exp_addr[5] = 32'h128; exp_data[5] = 32'h22;
      for (int k = 0; k < 6; k++) begin
         sbif.enq_addr = 32'h120 + 32'(4 * k);
         sbif.enq_data = 32'h20 + 32'(k);
         #1;
         check("wrap_head_addr", sbif.deq_addr, exp_addr[k]);
         check("wrap_head_data", sbif.deq_data, exp_data[k]);
         step();
      end
      sbif.enq_valid = 1'b0;
      check("wrap_count", 32'(sbif.count_out), 32'd3);
      for (int k = 0; k < 3; k++) begin
         check("drain_addr", sbif.deq_addr, 32'h12C + 32'(4 * k));
         check("drain_data", sbif.deq_data, 32'h23 + 32'(k));
         step();
      end
      sbif.deq_req = 1'b0;
      check("drain_count", 32'(sbif.count_out), 32'd0);
      check("drain_deq_valid", 32'(sbif.deq_valid), 32'd0);
      check("drain_deq_addr", sbif.deq_addr, 32'd0);
      check("drain_deq_data", sbif.deq_data, 32'd0);

      // Forwarding: two stores to one word, youngest wins
      sbif.enq_valid = 1'b1; sbif.enq_addr = 32'h200; sbif.enq_data = 32'h11;
      step();
      sbif.enq_data = 32'h22;
      step();
      sbif.enq_valid = 1'b0;
      check("fwd_nodedup_count", 32'(sbif.count_out), 32'd2);
      sbif.load_addr = 32'h200;
      #1;
      check("fwd_200_hit", 32'(sbif.sb_load_hit), 32'd1);
      check("fwd_200_data", sbif.sb_load_data, 32'h22);
      sbif.load_addr = 32'h202;
      #1;
      check("fwd_202_hit", 32'(sbif.sb_load_hit), 32'd1);
      check("fwd_202_data", sbif.sb_load_data, 32'h22);
      sbif.load_addr = 32'h204;
      #1;
      check("fwd_204_hit", 32'(sbif.sb_load_hit), 32'd0);
      check("fwd_204_data", sbif.sb_load_data, 32'd0);

      // Same-cycle store is not forwarded, next cycle it is
      sbif.enq_valid = 1'b1; sbif.enq_addr = 32'h300; sbif.enq_data = 32'h33;
      sbif.load_addr = 32'h300;
      #1;
      check("same_cycle_hit", 32'(sbif.sb_load_hit), 32'd0);
      step();
      sbif.enq_valid = 1'b0;
      check("next_cycle_hit", 32'(sbif.sb_load_hit), 32'd1);
      check("next_cycle_data", sbif.sb_load_data, 32'h33);
      check("pre_flush_count", 32'(sbif.count_out), 32'd3);

      // Flush with a simultaneous enqueue
      sbif.flush = 1'b1; sbif.enq_valid = 1'b1;
      sbif.enq_addr = 32'h400; sbif.enq_data = 32'h44;
      step();
      sbif.flush = 1'b0; sbif.enq_valid = 1'b0;
      check("flush_count", 32'(sbif.count_out), 32'd0);
      check("flush_deq_valid", 32'(sbif.deq_valid), 32'd0);
      check("flush_hit", 32'(sbif.sb_load_hit), 32'd0);
      check_all_invalid("flush_valid");

      // Synchronous reset in the middle of filling
      sbif.enq_valid = 1'b1; sbif.enq_addr = 32'h500; sbif.enq_data = 32'h55;
      step();
      sbif.enq_addr = 32'h504;
      step();
      check("midfill_count", 32'(sbif.count_out), 32'd2);
      rst = 1'b1;
      step();
      rst = 1'b0; sbif.enq_valid = 1'b0;
      check("reset_count", 32'(sbif.count_out), 32'd0);
      check("reset_deq_valid", 32'(sbif.deq_valid), 32'd0);
      check("reset_enq_ready", 32'(sbif.enq_ready), 32'd1);
      check_all_invalid("reset_valid");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
